// File: rtl/storesel_ctrl.sv
// Store byte-select controller: lane-aligns store data, builds byte enables and
// issues one or two word-aligned write beats over a we/ack memory handshake.
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// BEAT0 | first (or only) write beat on the memory port, waiting for mem_ack
// BEAT1 | second beat of a word-crossing store, waiting for mem_ack
// DONE  | done pulse (with err if the request was rejected), back to IDLE
module storesel_ctrl #(
  parameter int n           = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_sel,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_data,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  output logic [3:0]   mem_be,
  input  logic         mem_ack,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t         state;
  logic [3:0]     base_be;
  logic [n-1:0]   masked;
  logic           legal;
  logic [7:0]     be8;
  logic [2*n-1:0] d64;
  logic           split;
  logic [n-1:0]   beat0_addr;
  logic [n-1:0]   b1_addr;
  logic [n-1:0]   b1_wdata;
  logic [3:0]     b1_be;
  logic           split_q;

  // Decode the incoming request: size mask, lane shift and word-crossing detect
  always_comb begin
    base_be = 4'b0000;
    masked  = '0;
    legal   = 1'b1;
    case (req_sel)
      3'b000: begin
        base_be = 4'b1111;
        masked  = req_data;
      end
      3'b001: begin
        base_be = 4'b0011;
        masked  = {{(n-16){1'b0}}, req_data[15:0]};
      end
      3'b010: begin
        base_be = 4'b0001;
        masked  = {{(n-8){1'b0}}, req_data[7:0]};
      end
      default: legal = 1'b0;
    endcase
    be8        = {4'b0000, base_be} << req_addr[1:0];
    d64        = {{n{1'b0}}, masked} << {req_addr[1:0], 3'b000};
    split      = |be8[7:4];
    beat0_addr = {req_addr[n-1:2], 2'b00};
  end

  assign req_ready = (state == IDLE);

  // Sequencer: accept, drive beats until acked, then pulse done for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      done      <= 1'b0;
      err       <= 1'b0;
      b1_addr   <= '0;
      b1_wdata  <= '0;
      b1_be     <= 4'b0000;
      split_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req_valid) begin
            if (!legal || (split && (MISALIGN_EN == 0))) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= BEAT0;
              mem_we    <= 1'b1;
              mem_addr  <= beat0_addr;
              mem_wdata <= d64[n-1:0];
              mem_be    <= be8[3:0];
              b1_addr   <= beat0_addr + n'(4);
              b1_wdata  <= d64[2*n-1:n];
              b1_be     <= be8[7:4];
              split_q   <= split;
            end
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            if (split_q) begin
              state     <= BEAT1;
              mem_addr  <= b1_addr;
              mem_wdata <= b1_wdata;
              mem_be    <= b1_be;
            end else begin
              state  <= DONE;
              mem_we <= 1'b0;
              done   <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            state  <= DONE;
            mem_we <= 1'b0;
            done   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_storesel_ctrl.sv
// Directed bench for storesel_ctrl: single-beat, split, rejected, illegal,
// stalled and reset-abandoned stores against hand-computed beats.
module tb_storesel_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_sel = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        done;
  logic        err;

  logic        rj_valid = 1'b0;
  logic        rj_ready;
  logic        rj_we;
  logic [31:0] rj_addr;
  logic [31:0] rj_wdata;
  logic [3:0]  rj_be;
  logic        rj_done;
  logic        rj_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  storesel_ctrl #(.n(32), .MISALIGN_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_addr(req_addr), .req_data(req_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .done(done), .err(err)
  );

  storesel_ctrl #(.n(32), .MISALIGN_EN(0)) u_rej (
    .clk(clk), .rst_n(rst_n), .req_valid(rj_valid), .req_ready(rj_ready),
    .req_sel(req_sel), .req_addr(req_addr), .req_data(req_data),
    .mem_we(rj_we), .mem_addr(rj_addr), .mem_wdata(rj_wdata), .mem_be(rj_be),
    .mem_ack(mem_ack), .done(rj_done), .err(rj_err)
  );

  // single-beat vectors: sel, addr, data -> word addr, be, wdata
  logic [2:0]  s_sel  [3] = '{3'b000, 3'b010, 3'b001};
  logic [31:0] s_addr [3] = '{32'h100, 32'h203, 32'h302};
  logic [31:0] s_data [3] = '{32'hDEADBEEF, 32'h12345678, 32'hAAAA5555};
  logic [31:0] s_eaddr[3] = '{32'h100, 32'h200, 32'h300};
  logic [3:0]  s_ebe  [3] = '{4'b1111, 4'b1000, 4'b1100};
  logic [31:0] s_ewd  [3] = '{32'hDEADBEEF, 32'h78000000, 32'h55550000};

  // split vectors
  logic [2:0]  p_sel  [2] = '{3'b000, 3'b001};
  logic [31:0] p_addr [2] = '{32'h401, 32'hFFFFFFFF};
  logic [31:0] p_data [2] = '{32'h11223344, 32'hCAFEBEEF};
  logic [31:0] p_a0   [2] = '{32'h400, 32'hFFFFFFFC};
  logic [3:0]  p_be0  [2] = '{4'b1110, 4'b1000};
  logic [31:0] p_wd0  [2] = '{32'h22334400, 32'hEF000000};
  logic [31:0] p_a1   [2] = '{32'h404, 32'h00000000};
  logic [3:0]  p_be1  [2] = '{4'b0001, 4'b0001};
  logic [31:0] p_wd1  [2] = '{32'h00000011, 32'h000000BE};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one request on the main DUT across its accept edge (cycle T)
  task automatic issue(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] data);
    req_sel   = sel;
    req_addr  = addr;
    req_data  = data;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    total++; if (mem_be !== 4'b0000) begin bad++; $display("FAIL reset_be got=%b exp=0000", mem_be); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_done_err got=%b%b exp=00", done, err); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    rst_n = 1'b1;
    step();
    // stray ack while idle must do nothing
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    total++; if (mem_we !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL idle_ack got we=%b done=%b ready=%b exp we=0 done=0 ready=1", mem_we, done, req_ready);
    end
  endtask

  task automatic test_single_beat();
    for (int i = 0; i < 3; i++) begin
      issue(s_sel[i], s_addr[i], s_data[i]);
      // cycle T+1: beat on the bus, ack immediately
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL single%0d_we got=%b exp=1", i, mem_we); end
      total++; if (mem_addr !== s_eaddr[i]) begin bad++; $display("FAIL single%0d_addr got=%h exp=%h", i, mem_addr, s_eaddr[i]); end
      total++; if (mem_be !== s_ebe[i]) begin bad++; $display("FAIL single%0d_be got=%b exp=%b", i, mem_be, s_ebe[i]); end
      total++; if (mem_wdata !== s_ewd[i]) begin bad++; $display("FAIL single%0d_wdata got=%h exp=%h", i, mem_wdata, s_ewd[i]); end
      total++; if (req_ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL single%0d_busy got ready=%b done=%b exp 0 0", i, req_ready, done); end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      // cycle T+2
      total++; if (done !== 1'b1 || err !== 1'b0 || mem_we !== 1'b0) begin
        bad++; $display("FAIL single%0d_done got done=%b err=%b we=%b exp 1 0 0", i, done, err, mem_we);
      end
      step();
      total++; if (done !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL single%0d_idle got done=%b ready=%b exp 0 1", i, done, req_ready); end
    end
  endtask

  task automatic test_split();
    for (int i = 0; i < 2; i++) begin
      issue(p_sel[i], p_addr[i], p_data[i]);
      total++; if (mem_we !== 1'b1 || mem_addr !== p_a0[i] || mem_be !== p_be0[i] || mem_wdata !== p_wd0[i]) begin
        bad++; $display("FAIL split%0d_beat0 got we=%b a=%h be=%b d=%h exp 1 %h %b %h", i, mem_we, mem_addr, mem_be, mem_wdata, p_a0[i], p_be0[i], p_wd0[i]);
      end
      mem_ack = 1'b1;
      step();
      total++; if (mem_we !== 1'b1 || mem_addr !== p_a1[i] || mem_be !== p_be1[i] || mem_wdata !== p_wd1[i]) begin
        bad++; $display("FAIL split%0d_beat1 got we=%b a=%h be=%b d=%h exp 1 %h %b %h", i, mem_we, mem_addr, mem_be, mem_wdata, p_a1[i], p_be1[i], p_wd1[i]);
      end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL split%0d_early_done got=%b exp=0", i, done); end
      step();
      mem_ack = 1'b0;
      // cycle T+3
      total++; if (done !== 1'b1 || err !== 1'b0 || mem_we !== 1'b0) begin
        bad++; $display("FAIL split%0d_done got done=%b err=%b we=%b exp 1 0 0", i, done, err, mem_we);
      end
      step();
    end
  endtask

  task automatic test_reject();
    req_sel  = 3'b000;
    req_addr = 32'h401;
    req_data = 32'h11223344;
    rj_valid = 1'b1;
    step();
    rj_valid = 1'b0;
    total++; if (rj_done !== 1'b1 || rj_err !== 1'b1) begin bad++; $display("FAIL reject_done got done=%b err=%b exp 1 1", rj_done, rj_err); end
    total++; if (rj_we !== 1'b0) begin bad++; $display("FAIL reject_we got=%b exp=0", rj_we); end
    step();
    total++; if (rj_done !== 1'b0 || rj_we !== 1'b0 || rj_ready !== 1'b1) begin
      bad++; $display("FAIL reject_after got done=%b we=%b ready=%b exp 0 0 1", rj_done, rj_we, rj_ready);
    end
    // aligned word on the rejecting instance still goes through
    req_addr = 32'h500;
    rj_valid = 1'b1;
    step();
    rj_valid = 1'b0;
    total++; if (rj_we !== 1'b1 || rj_addr !== 32'h500 || rj_be !== 4'b1111 || rj_wdata !== 32'h11223344) begin
      bad++; $display("FAIL reject_aligned got we=%b a=%h be=%b d=%h exp 1 500 1111 11223344", rj_we, rj_addr, rj_be, rj_wdata);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++; if (rj_done !== 1'b1 || rj_err !== 1'b0) begin bad++; $display("FAIL reject_aligned_done got done=%b err=%b exp 1 0", rj_done, rj_err); end
    step();
  endtask

  task automatic test_illegal();
    issue(3'b101, 32'h600, 32'h01020304);
    total++; if (done !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL illegal_done got done=%b err=%b exp 1 1", done, err); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL illegal_we got=%b exp=0", mem_we); end
    step();
    total++; if (done !== 1'b0 || err !== 1'b0 || mem_we !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL illegal_after got done=%b err=%b we=%b ready=%b exp 0 0 0 1", done, err, mem_we, req_ready);
    end
  endtask

  task automatic test_stall();
    issue(3'b010, 32'h203, 32'h12345678);
    // second request presented while busy must be ignored
    req_sel   = 3'b000;
    req_addr  = 32'h700;
    req_data  = 32'hFFFFFFFF;
    req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      total++; if (mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_be !== 4'b1000 || mem_wdata !== 32'h78000000) begin
        bad++; $display("FAIL stall%0d_bus got we=%b a=%h be=%b d=%h exp 1 200 1000 78000000", c, mem_we, mem_addr, mem_be, mem_wdata);
      end
      total++; if (req_ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL stall%0d_busy got ready=%b done=%b exp 0 0", c, req_ready, done); end
      step();
    end
    mem_ack = 1'b1;
    step();
    mem_ack   = 1'b0;
    req_valid = 1'b0;
    total++; if (done !== 1'b1 || err !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL stall_done got done=%b err=%b ready=%b exp 1 0 0", done, err, req_ready);
    end
    step();
    step();
    total++; if (mem_we !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL stall_second_ignored got we=%b ready=%b exp 0 1", mem_we, req_ready); end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    issue(3'b000, 32'h401, 32'h11223344);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h404) begin bad++; $display("FAIL rstmid_in_beat1 got we=%b a=%h exp 1 404", mem_we, mem_addr); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL rstmid_async got we=%b ready=%b done=%b exp 0 1 0", mem_we, req_ready, done);
    end
    step();
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done === 1'b1 || mem_we === 1'b1) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL rstmid_abandon got activity=%b exp=0", saw_done); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_split();
    test_reject();
    test_illegal();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
